// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared opcodes, tag encoding, FSM states and operand helpers
package tomasulo_pkg;

  localparam int TAG_W = 3;
  localparam logic [TAG_W-1:0] READY = '0;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0100;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_MUL,
    CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic [15:0]      value;
    logic [TAG_W-1:0] tag;
  } operand_t;

  // Anything outside the three known opcodes (X/Z included) falls to illegal.
  function automatic op_class_t classify(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: return CLS_ADD;
      OP_MUL:         return CLS_MUL;
      default:        return CLS_ILLEGAL;
    endcase
  endfunction

  // Ready register wins, then a same-cycle CDB forward, else wait on the producer tag.
  function automatic operand_t resolve(input logic [TAG_W-1:0] status_tag,
                                       input logic [15:0]      rf_data,
                                       input logic             cdb_valid,
                                       input logic [TAG_W-1:0] cdb_tag,
                                       input logic [15:0]      cdb_data);
    operand_t r;
    if (status_tag == READY) begin
      r.value = rf_data;
      r.tag   = READY;
    end else if (cdb_valid && (cdb_tag == status_tag)) begin
      r.value = cdb_data;
      r.tag   = READY;
    end else begin
      r.value = '0;
      r.tag   = status_tag;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_status.sv
// rtl/reg_status.sv - register status table: producer tag per architectural register
module reg_status
  import tomasulo_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [2:0]       addr_j,
  input  logic [2:0]       addr_k,
  output logic [TAG_W-1:0] tag_j,
  output logic [TAG_W-1:0] tag_k,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag
);

  logic [TAG_W-1:0] status [8];

  // Reads see the pre-edge table, so an instruction whose rd matches a source sees the old tag.
  assign tag_j = status[addr_j];
  assign tag_k = status[addr_k];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) status[i] <= READY;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en && (wr_addr == 3'(i))) status[i] <= wr_tag;
        else if (clr_en && (status[i] == clr_tag)) status[i] <= READY;
      end
    end
  end

endmodule

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - in-order issue stage dispatching to add/mul reservation stations
module issue_unit
  import tomasulo_pkg::*;
#(
  parameter int ADD_RS = 3,
  parameter int MUL_RS = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              enableIn,
  input  logic [15:0]       instructionIn,
  output logic              disponivel,
  input  logic [ADD_RS-1:0] addFree,
  input  logic [MUL_RS-1:0] mulFree,
  output logic [2:0]        rfAddrJ,
  output logic [2:0]        rfAddrK,
  input  logic [15:0]       rfDataJ,
  input  logic [15:0]       rfDataK,
  input  logic              cdbValid,
  input  logic [TAG_W-1:0]  cdbTag,
  input  logic [15:0]       cdbData,
  output logic              issueAdd,
  output logic              issueMul,
  output logic [TAG_W-1:0]  issueTag,
  output logic [3:0]        issueOp,
  output logic [15:0]       Vj,
  output logic [15:0]       Vk,
  output logic [TAG_W-1:0]  Qj,
  output logic [TAG_W-1:0]  Qk
);

  logic [1:0]       state, state_nxt;
  logic [15:0]      instr_q;
  logic [2:0]       rd;
  logic [TAG_W-1:0] tag_j, tag_k, add_tag, mul_tag;
  logic             add_avail, mul_avail, dispatch;
  op_class_t        op_class;
  operand_t         src_j, src_k;
  logic             unused_hi;

  assign issueOp   = instr_q[3:0];
  assign rfAddrK   = instr_q[6:4];
  assign rfAddrJ   = instr_q[9:7];
  assign rd        = instr_q[12:10];
  assign unused_hi = ^instr_q[15:13];
  assign op_class  = classify(issueOp);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_FETCH;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_WAIT) && enableIn) instr_q <= instructionIn;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  if (enableIn) state_nxt = S_HOLD;
      S_HOLD: begin
        if (op_class == CLS_ILLEGAL) state_nxt = S_STOP;
        else if (dispatch)           state_nxt = S_FETCH;
      end
      default: state_nxt = S_STOP;
    endcase
  end

  // Scan downward so the lowest-index free station is the last assignment and wins.
  always_comb begin
    add_avail = 1'b0;
    add_tag   = READY;
    for (int i = ADD_RS - 1; i >= 0; i--) begin
      if (addFree[i]) begin
        add_avail = 1'b1;
        add_tag   = TAG_W'(i + 1);
      end
    end
    mul_avail = 1'b0;
    mul_tag   = READY;
    for (int j = MUL_RS - 1; j >= 0; j--) begin
      if (mulFree[j]) begin
        mul_avail = 1'b1;
        mul_tag   = TAG_W'(ADD_RS + 1 + j);
      end
    end
  end

  assign issueAdd   = (state == S_HOLD) && (op_class == CLS_ADD) && add_avail;
  assign issueMul   = (state == S_HOLD) && (op_class == CLS_MUL) && mul_avail;
  assign dispatch   = issueAdd || issueMul;
  assign issueTag   = issueMul ? mul_tag : (issueAdd ? add_tag : READY);
  assign disponivel = Resetn && (state == S_FETCH);

  assign src_j = resolve(tag_j, rfDataJ, cdbValid, cdbTag, cdbData);
  assign src_k = resolve(tag_k, rfDataK, cdbValid, cdbTag, cdbData);
  assign Vj    = src_j.value;
  assign Qj    = src_j.tag;
  assign Vk    = src_k.value;
  assign Qk    = src_k.tag;

  reg_status u_status (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .addr_j  (rfAddrJ),
    .addr_k  (rfAddrK),
    .tag_j   (tag_j),
    .tag_k   (tag_k),
    .wr_en   (dispatch),
    .wr_addr (rd),
    .wr_tag  (issueTag),
    .clr_en  (cdbValid),
    .clr_tag (cdbTag)
  );

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - directed table, corner sequences and randomized model check for issue_unit
module tb_issue_unit;

  localparam int ADD_RS_TB = 3;

  logic        Clock, Resetn, enableIn, disponivel;
  logic [15:0] instructionIn, rfDataJ, rfDataK, cdbData, Vj, Vk;
  logic [2:0]  addFree, rfAddrJ, rfAddrK, cdbTag, issueTag, Qj, Qk;
  logic [1:0]  mulFree;
  logic        cdbValid, issueAdd, issueMul;
  logic [3:0]  issueOp;

  issue_unit #(.ADD_RS(3), .MUL_RS(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .enableIn(enableIn), .instructionIn(instructionIn),
    .disponivel(disponivel), .addFree(addFree), .mulFree(mulFree),
    .rfAddrJ(rfAddrJ), .rfAddrK(rfAddrK), .rfDataJ(rfDataJ), .rfDataK(rfDataK),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .issueAdd(issueAdd), .issueMul(issueMul), .issueTag(issueTag), .issueOp(issueOp),
    .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        add;
    logic        mul;
    logic [2:0]  tag;
    logic [15:0] vj;
    logic [2:0]  qj;
    logic [15:0] vk;
    logic [2:0]  qk;
  } out_t;

  typedef struct packed {
    logic [15:0] ins;
    logic [2:0]  af;
    logic [1:0]  mf;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cd;
    logic [15:0] rfj;
    logic [15:0] rfk;
    logic        e_add;
    logic        e_mul;
    logic [2:0]  e_tag;
    logic [15:0] e_vj;
    logic [2:0]  e_qj;
    logic [15:0] e_vk;
    logic [2:0]  e_qk;
  } vec_t;

  int   n_checks, n_fail;
  int   model_status [8];
  vec_t tbl [6];
  out_t got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] ref_src(input int st, input logic [15:0] rf, input logic cv,
                                          input logic [2:0] ct, input logic [15:0] cd);
    if (st == 0) return {rf, 3'd0};
    if (cv && (int'(ct) == st)) return {cd, 3'd0};
    return {16'd0, 3'(st)};
  endfunction

  task automatic model_clear();
    for (int e = 0; e < 8; e++) model_status[e] = 0;
  endtask

  // Full FETCH/WAIT/HOLD handshake for one legal instruction; class mask must have a free bit.
  task automatic do_instr(input logic [15:0] ins, input logic [2:0] af, input logic [1:0] mf,
                          input int stall_n, input logic cv, input logic [2:0] ct,
                          input logic [15:0] cd, input logic [15:0] rfj, input logic [15:0] rfk,
                          output out_t o);
    logic [3:0]  op;
    logic [2:0]  mask;
    logic [18:0] sj, sk;
    logic        is_mul;
    int          rs, rt, rd, idx, etag, n;
    op     = ins[3:0];
    rt     = int'(ins[6:4]);
    rs     = int'(ins[9:7]);
    rd     = int'(ins[12:10]);
    is_mul = (op == 4'b0100);
    @(negedge Clock);
    chk("fetch_disponivel", disponivel, 1);
    chk("fetch_strobe", {issueAdd, issueMul}, 0);
    @(posedge Clock); #1;
    enableIn = 1'b1;
    instructionIn = ins;
    @(negedge Clock);
    chk("wait_disponivel", disponivel, 0);
    chk("wait_strobe", {issueAdd, issueMul}, 0);
    @(posedge Clock); #1;
    enableIn = 1'b0;
    instructionIn = 16'($urandom);
    for (int s = 0; s < stall_n; s++) begin
      addFree = '0;
      mulFree = '0;
      @(negedge Clock);
      chk("stall_strobe", {issueAdd, issueMul}, 0);
      chk("stall_disponivel", disponivel, 0);
      @(posedge Clock); #1;
    end
    addFree = af; mulFree = mf; cdbValid = cv; cdbTag = ct; cdbData = cd;
    rfDataJ = rfj; rfDataK = rfk;
    mask = is_mul ? {1'b0, mf} : af;
    n    = is_mul ? 2 : 3;
    idx  = -1;
    for (int b = n - 1; b >= 0; b--) if (mask[b]) idx = b;
    etag = is_mul ? ADD_RS_TB + 1 + idx : idx + 1;
    sj   = ref_src(model_status[rs], rfj, cv, ct, cd);
    sk   = ref_src(model_status[rt], rfk, cv, ct, cd);
    @(negedge Clock);
    o.add = issueAdd; o.mul = issueMul; o.tag = issueTag;
    o.vj = Vj; o.qj = Qj; o.vk = Vk; o.qk = Qk;
    chk("issue_add", issueAdd, !is_mul);
    chk("issue_mul", issueMul, is_mul);
    chk("issue_tag", issueTag, etag);
    chk("issue_op", issueOp, op);
    chk("rf_addr", {rfAddrJ, rfAddrK}, {rs[2:0], rt[2:0]});
    chk("src_j", {Vj, Qj}, sj);
    chk("src_k", {Vk, Qk}, sk);
    @(posedge Clock); #1;
    cdbValid = 1'b0; addFree = '0; mulFree = '0;
    for (int e = 0; e < 8; e++) if (cv && (model_status[e] == int'(ct))) model_status[e] = 0;
    model_status[rd] = etag;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [15:0] rins;
    int          k, stl;
    n_checks = 0; n_fail = 0;
    Resetn = 1'b0; enableIn = 1'b0; instructionIn = '0; addFree = '0; mulFree = '0;
    rfDataJ = '0; rfDataK = '0; cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
    model_clear();

    //          ins       af      mf     cv    ct    cd        rfj       rfk       add   mul   tag   vj        qj    vk        qk
    tbl[0] = '{16'h0CA0, 3'b111, 2'b00, 1'b0, 3'd0, 16'h0000, 16'h1111, 16'h2222, 1'b1, 1'b0, 3'd1, 16'h1111, 3'd0, 16'h2222, 3'd0};
    tbl[1] = '{16'h1591, 3'b110, 2'b00, 1'b0, 3'd0, 16'h0000, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 3'd2, 16'h0000, 3'd1, 16'h5555, 3'd0};
    tbl[2] = '{16'h1591, 3'b100, 2'b00, 1'b1, 3'd1, 16'hBEEF, 16'hAAAA, 16'h6666, 1'b1, 1'b0, 3'd3, 16'hBEEF, 3'd0, 16'h6666, 3'd0};
    tbl[3] = '{16'h1AB4, 3'b000, 2'b01, 1'b1, 3'd4, 16'h4444, 16'h7777, 16'h8888, 1'b0, 1'b1, 3'd4, 16'h0000, 3'd3, 16'h8888, 3'd0};
    tbl[4] = '{16'h0750, 3'b001, 2'b00, 1'b0, 3'd0, 16'h0000, 16'h0001, 16'h0002, 1'b1, 1'b0, 3'd1, 16'h0000, 3'd4, 16'h0000, 3'd3};
    tbl[5] = '{16'h0AE0, 3'b010, 2'b00, 1'b1, 3'd3, 16'h3333, 16'h0009, 16'h000A, 1'b1, 1'b0, 3'd2, 16'h3333, 3'd0, 16'h0000, 3'd4};

    @(negedge Clock);
    chk("reset_disponivel", disponivel, 0);
    chk("reset_strobe", {issueAdd, issueMul}, 0);
    @(posedge Clock); #1;
    Resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_instr(tbl[i].ins, tbl[i].af, tbl[i].mf, 0, tbl[i].cv, tbl[i].ct, tbl[i].cd,
               tbl[i].rfj, tbl[i].rfk, got);
      chk($sformatf("vec%0d_strobes", i), {got.add, got.mul}, {tbl[i].e_add, tbl[i].e_mul});
      chk($sformatf("vec%0d_tag", i), got.tag, tbl[i].e_tag);
      chk($sformatf("vec%0d_j", i), {got.vj, got.qj}, {tbl[i].e_vj, tbl[i].e_qj});
      chk($sformatf("vec%0d_k", i), {got.vk, got.qk}, {tbl[i].e_vk, tbl[i].e_qk});
    end

    // MUL R7,R1,R2 starved of mul stations, then station 1 frees up.
    do_instr(16'h1CA4, 3'b000, 2'b10, 3, 1'b0, 3'd0, 16'h0, 16'h0101, 16'h0202, got);
    chk("mul_stall_strobe", got.mul, 1);
    chk("mul_stall_tag", got.tag, 5);
    chk("mul_stall_q", {got.qj, got.qk}, {3'd1, 3'd2});

    // Reset while an ADD R4,R7,R1 sits stalled in HOLD.
    @(negedge Clock);
    chk("hold_fetch_disponivel", disponivel, 1);
    @(posedge Clock); #1;
    enableIn = 1'b1; instructionIn = 16'h1390;
    @(posedge Clock); #1;
    enableIn = 1'b0; addFree = '0;
    @(negedge Clock);
    chk("hold_stalled", {issueAdd, issueMul}, 0);
    @(posedge Clock); #1;
    Resetn = 1'b0; addFree = 3'b111; mulFree = 2'b11;
    @(negedge Clock);
    chk("hold_reset_strobe", {issueAdd, issueMul}, 0);
    chk("hold_reset_disponivel", disponivel, 0);
    @(posedge Clock); #1;
    Resetn = 1'b1; addFree = '0; mulFree = '0;
    model_clear();
    do_instr(16'h1390, 3'b111, 2'b00, 0, 1'b0, 3'd0, 16'h0, 16'h1234, 16'h5678, got);
    chk("post_reset_ready", {got.vj, got.qj, got.vk, got.qk}, {16'h1234, 3'd0, 16'h5678, 3'd0});

    // Illegal opcode parks the unit in STOP until reset.
    @(negedge Clock);
    chk("illegal_fetch", disponivel, 1);
    @(posedge Clock); #1;
    enableIn = 1'b1; instructionIn = 16'h0002;
    @(posedge Clock); #1;
    enableIn = 1'b0; addFree = 3'b111; mulFree = 2'b11;
    repeat (4) begin
      @(negedge Clock);
      chk("stop_strobe", {issueAdd, issueMul}, 0);
      chk("stop_disponivel", disponivel, 0);
    end
    @(posedge Clock); #1;
    Resetn = 1'b0;
    @(negedge Clock);
    chk("stop_reset_disponivel", disponivel, 0);
    @(posedge Clock); #1;
    Resetn = 1'b1; addFree = '0; mulFree = '0;
    model_clear();

    for (int n = 0; n < 40; n++) begin
      k    = $urandom_range(0, 2);
      rop  = (k == 0) ? 4'b0000 : ((k == 1) ? 4'b0001 : 4'b0100);
      rins = {3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), rop};
      stl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      do_instr(rins, 3'($urandom_range(1, 7)), 2'($urandom_range(1, 3)), stl,
               1'($urandom_range(0, 1)), 3'($urandom_range(1, 5)), 16'($urandom),
               16'($urandom), 16'($urandom), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
